// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-level constants
// common to uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops preset to
// the idle (stop) level so reset never looks like a start bit.
import uart_pkg::*;

module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= STOP_BIT;
      q    <= STOP_BIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ack holding register, overrun and
// framing-error flags. Define UART_RX_PARITY_EN to add an even-parity bit.
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [15:0]       LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]       MID_CNT  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic                 rx_s;
  logic                 rx_prev;
  logic [15:0]          clk_cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 commit;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit, parity_next;
`endif

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start requires a high-to-low transition, so a held break after a
  // framing error cannot retrigger the receiver.
  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt + 16'd1;
    idx_next   = bit_idx;
    shift_next = shift;
    commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next = parity_bit;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_s == START_BIT && rx_prev == STOP_BIT) state_next = START;
      end
      START: begin
        if (clk_cnt == MID_CNT) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = (rx_s == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          idx_next            = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_next    = '0;
          parity_next = rx_s;
          state_next  = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_next   = '0;
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= STOP_BIT;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      clk_cnt <= cnt_next;
      bit_idx <= idx_next;
      shift   <= shift_next;
      busy    <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  // Commit beats a simultaneous ack; an ack in that cycle means the old byte
  // was consumed, so no overrun is reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (commit) begin
      data      <= shift;
      valid     <= 1'b1;
      frame_err <= (rx_s != STOP_BIT);
      overrun   <= ack ? 1'b0 : (overrun | valid);
`ifdef UART_RX_PARITY_EN
      parity_err <= (^shift) ^ parity_bit;
`endif
    end else if (ack && valid) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16, 8 data bits.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(C);
  endtask

  // Drives start, data (and parity) bits, then sets the stop level and returns
  // at the very start of the stop bit.
  task automatic start_frame(input logic [7:0] b, input logic par, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    rx = stop_val;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_val);
    start_frame(b, par, stop_val);
    wait_cycles(C);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    wait_cycles(1);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    wait_cycles(3);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cycles(5);

    // 0xA5: stop-bit centre sampled 11 edges into the stop bit
    start_frame(8'hA5, 1'b0, 1'b1);
    wait_cycles(10);
    check("a5_valid_before", valid, 0);
    wait_cycles(1);
    check("a5_valid_rise", valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_frame_err", frame_err, 0);
    check("a5_overrun", overrun, 0);
    check("a5_busy_idle", busy, 0);
    wait_cycles(C - 11);
    pulse_ack();
    check("a5_ack_valid", valid, 0);

    // Short low glitch aborts in START
    rx = 1'b0;
    wait_cycles(5);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    wait_cycles(C);
    check("glitch_busy_done", busy, 0);
    check("glitch_valid", valid, 0);

    // 0x3C with stop bit forced low, then line high
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cycles(C);
    check("fe_data", data, 8'h3C);
    check("fe_valid", valid, 1);
    check("fe_frame_err", frame_err, 1);
    check("fe_busy", busy, 0);
    pulse_ack();
    check("fe_ack_valid", valid, 0);
    check("fe_ack_frame_err", frame_err, 0);

    // Back-to-back 0x11, 0x22 without ack
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_data", data, 8'h22);
    check("ovr_valid", valid, 1);
    check("ovr_overrun", overrun, 1);
    pulse_ack();
    check("ovr_ack_overrun", overrun, 0);
    check("ovr_ack_valid", valid, 0);

    // Same pair with ack landing on the commit edge of 0x22
    send_frame(8'h11, 1'b0, 1'b1);
    start_frame(8'h22, 1'b0, 1'b1);
    wait_cycles(10);
    ack = 1'b1;
    wait_cycles(1);
    ack = 1'b0;
    check("ackc_valid", valid, 1);
    check("ackc_overrun", overrun, 0);
    check("ackc_data", data, 8'h22);
    wait_cycles(C - 11);
    pulse_ack();
    check("ackc_cleared", valid, 0);

    // Reset mid-bit 4 of 0xFF, then clean 0x81
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_cycles(C / 2);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_data", data, 0);
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(5 * C);
    check("midrst_valid", valid, 0);
    check("midrst_busy_after", busy, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    check("r81_data", data, 8'h81);
    check("r81_valid", valid, 1);
    check("r81_frame_err", frame_err, 0);
    check("r81_overrun", overrun, 0);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_valid", valid, 1);
    check("par_ok_err", parity_err, 0);
    pulse_ack();
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_valid", valid, 1);
    check("par_bad_err", parity_err, 1);
    pulse_ack();
    check("par_ack_err", parity_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: 8N1 by default. One start bit (0), 8 data bits LSB first, one stop bit (1); idle line is 1.
- Oversamples rx using a clock-cycle count per bit and samples each bit at its centre.
- Presents each byte to downstream logic through a valid/ack holding register with overrun and framing-error reporting.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk.
- ack  input  1  one-cycle pulse; consumer has taken data.
- data  output  DATA_BITS  last received byte.
- valid  output  1  data holds an unconsumed byte.
- frame_err  output  1  stop bit sampled as 0 on the last frame; sticky until ack.
- overrun  output  1  a byte completed while valid=1; sticky until ack.
- busy  output  1  receiver is not in IDLE.

Behaviour:
- Reset:
  - On rst=1, asynchronously: data=0, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
  - Synchronizer flops preset to 1.
  - Reset asserted mid-frame discards the partial frame; no output changes beyond the reset values.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, giving 2 cycles of input latency.
- Counter: clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..DATA_BITS-1.
- State machine:
  - IDLE: when rx_s=0, go to START with clk_cnt=0.
  - START: when clk_cnt reaches (CLKS_PER_BIT/2)-1, check rx_s.
    - rx_s=0: go to DATA, clk_cnt=0, bit_idx=0.
    - rx_s=1: glitch; return to IDLE with no flags changed.
  - DATA: on each clk_cnt=CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] (LSB first).
    - After bit DATA_BITS-1, go to STOP.
  - STOP: on clk_cnt=CLKS_PER_BIT-1, sample the stop bit, commit the frame (rules below), go to IDLE.
- Commit rules:
  - data <= shift, valid <= 1.
  - frame_err <= (stop sample == 0).
  - overrun <= overrun | valid_before_commit.
  - On overrun the newer byte overwrites data.
- ack handling:
  - ack clears valid, frame_err and overrun on the next edge.
  - ack and commit in the same cycle: commit wins. valid=1 and frame_err reflect the new frame. overrun is not set, because the old byte was consumed.
  - ack while valid=0 is ignored.
- Framing error: the byte is still delivered (valid=1). IDLE re-arms only after rx_s=1 is seen, so a continuous break does not retrigger.
- busy = (state != IDLE), registered.
- Latency: the stop-bit sample to valid rising is 1 cycle. The rx falling edge to the centre of the start bit is 2 + CLKS_PER_BIT/2 cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit.
  - Adds output parity_err (1 bit), sticky until ack, set at commit when the XOR of the data bits and the parity bit is 1.
  - Frame length is 11 bits at the default width.
- Undefined: no PARITY state, no parity_err port, 8N1 behaviour.

Decomposition:
- Package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constant DEFAULT_CLKS_PER_BIT=16.
  - Frame-level constants START_BIT=0 and STOP_BIT=1, shared with uart_tx.
- One sub-module, uart_sync2: 2-flop synchronizer with async reset and preset-to-1. The block is otherwise a single FSM module.

Test Plan:
- Byte 0xA5, 8N1, CLKS_PER_BIT=16 -> valid rises 1 cycle after stop-bit centre; data=0xA5; frame_err=0, overrun=0; ack then clears valid.
- 0.3-bit low glitch on an idle line -> START aborts; busy returns to 0; valid stays 0.
- 0x3C sent with stop bit forced 0, then line held high -> data=0x3C, valid=1, frame_err=1; ack clears both.
- 0x11 then 0x22 back-to-back with no ack -> data=0x22, overrun=1; ack clears it. Repeat with ack on the exact commit cycle of 0x22 -> overrun=0, valid=1.
- rst pulsed mid-bit 4 of 0xFF, then 0x81 sent -> no output from the aborted frame; data=0x81 received cleanly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0. Same byte with parity bit 0 -> parity_err=1, valid=1.
